// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: decode/IF-ID handshake plus the shared byte memory port.
interface if_fetch_if;
  logic        stall_hold;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        mem_req;
  logic [31:0] mem_a;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stall_req;

  modport master (
    input  stall_hold, br_taken, br_addr, mem_gnt, mem_din,
    output mem_req, mem_a, if_pc, if_inst, if_valid, stall_req
  );

  modport slave (
    output stall_hold, br_taken, br_addr, mem_gnt, mem_din,
    input  mem_req, mem_a, if_pc, if_inst, if_valid, stall_req
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: assembles 32-bit words from a granted byte port,
// presents pc/inst to IF/ID, accepts decode redirects.
// Optional direct-mapped instruction cache enabled by defining IFETCH_ICACHE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned ICACHE_INDEX_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  if_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [1:0]  recv_cnt_q, recv_cnt_d;
  logic        pending_q, pending_d;
  logic [23:0] byte_buf_q, byte_buf_d;

  logic        granted_c;
  logic        done_c;
  logic        hit_c;
  logic [31:0] hit_data_c;
  logic        unused_c;

  assign granted_c = mem_req_q & bus.mem_gnt;
  // Last byte lands this cycle and is not being discarded by a redirect.
  assign done_c    = rdy & ~bus.br_taken & (state_q == FETCH) & pending_q & (recv_cnt_q == 2'd3);
  assign unused_c  = ^{bus.br_addr[1:0], ICACHE_INDEX_W};

`ifdef IFETCH_ICACHE_EN
  localparam int unsigned LINES = 1 << ICACHE_INDEX_W;
  localparam int unsigned TAG_W = 32 - ICACHE_INDEX_W - 2;

  logic [LINES-1:0]          cvalid_q, cvalid_d;
  logic [TAG_W-1:0]          ctag_q  [LINES];
  logic [31:0]               cdata_q [LINES];
  logic [ICACHE_INDEX_W-1:0] cidx_c;
  logic [TAG_W-1:0]          ctag_c;

  assign cidx_c     = pc_q[ICACHE_INDEX_W+1:2];
  assign ctag_c     = pc_q[31:ICACHE_INDEX_W+2];
  assign hit_c      = cvalid_q[cidx_c] && (ctag_q[cidx_c] == ctag_c);
  assign hit_data_c = cdata_q[cidx_c];

  // Line becomes valid when a byte-port fetch completes for it.
  always_comb begin
    cvalid_d = cvalid_q;
    if (done_c) cvalid_d[cidx_c] = 1'b1;
  end

  // Valid bits are the only cache state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) cvalid_q <= '0;
    else     cvalid_q <= cvalid_d;
  end

  // Tag/data fill with the freshly assembled word.
  always_ff @(posedge clk) begin
    if (done_c) begin
      ctag_q[cidx_c]  <= ctag_c;
      cdata_q[cidx_c] <= {bus.mem_din, byte_buf_q};
    end
  end
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
`endif

  // Next-state: issue/receive bytes, present, consume, redirect (redirect wins).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req_q;
    mem_a_d     = mem_a_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    pending_d   = pending_q;
    byte_buf_d  = byte_buf_q;

    if (rdy) begin
      pending_d = granted_c;
      if (granted_c) issue_cnt_d = issue_cnt_q + 3'd1;

      if ((state_q == FETCH) && pending_q) begin
        if (recv_cnt_q == 2'd3) begin
          if_inst_d   = {bus.mem_din, byte_buf_q};
          if_pc_d     = pc_q;
          if_valid_d  = 1'b1;
          state_d     = HOLD;
          issue_cnt_d = 3'd0;
          recv_cnt_d  = 2'd0;
        end else begin
          case (recv_cnt_q)
            2'd0:    byte_buf_d[7:0]   = bus.mem_din;
            2'd1:    byte_buf_d[15:8]  = bus.mem_din;
            default: byte_buf_d[23:16] = bus.mem_din;
          endcase
          recv_cnt_d = recv_cnt_q + 2'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (!if_valid_q) begin
            if (hit_c) begin
              if_inst_d  = hit_data_c;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              state_d    = HOLD;
            end else begin
              state_d     = FETCH;
              issue_cnt_d = 3'd0;
              recv_cnt_d  = 2'd0;
            end
          end
        end
        HOLD: begin
          if (if_valid_q && !bus.stall_hold) begin
            if_valid_d = 1'b0;
            pc_d       = pc_q + 32'd4;
            state_d    = IDLE;
          end
        end
        default: ;
      endcase

      if (bus.br_taken) begin
        pc_d        = {bus.br_addr[31:2], 2'b00};
        if_valid_d  = 1'b0;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        issue_cnt_d = 3'd0;
        recv_cnt_d  = 2'd0;
        pending_d   = 1'b0;
        state_d     = IDLE;
      end

      mem_req_d = (state_d == FETCH) && (issue_cnt_d < 3'd4);
      if (mem_req_d) mem_a_d = pc_d + 32'(issue_cnt_d);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_a_q     <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pending_q   <= 1'b0;
      byte_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_a_q     <= mem_a_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pending_q   <= pending_d;
      byte_buf_q  <= byte_buf_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.stall_req = ~if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by random traffic, all
// checked against a transaction-level model of pc sequencing and memory contents.
module tb_if_fetch;
  logic clk = 1'b0;
  logic rst;
  logic rdy;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0), .ICACHE_INDEX_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          k = 0;
  int          consumed = 0;
  logic [31:0] mpc = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'hC3A51F0E;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return 8'(w >> (8 * a[1:0]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check this cycle against the model, advance model, drive memory data.
  task automatic cyc();
    logic [7:0] dn;
    dn = rdy ? 8'($urandom) : bus.mem_din;
    chk("stall_req", 32'(bus.stall_req), 32'(!bus.if_valid));
    if (rdy) begin
      if (bus.mem_req && bus.mem_gnt) begin
        chk("issue_addr", bus.mem_a, mpc + 32'(k));
        k++;
        dn = byte_at(bus.mem_a);
      end
      if (bus.br_taken) begin
        mpc = {bus.br_addr[31:2], 2'b00};
        k = 0;
      end else if (bus.if_valid && !bus.stall_hold) begin
        chk("consume_pc", bus.if_pc, mpc);
        chk("consume_inst", bus.if_inst, word_at(mpc));
        mpc = mpc + 32'd4;
        k = 0;
        consumed++;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_din = dn;
  endtask

  task automatic wait_sig(input bit want_valid, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (want_valid ? bus.if_valid : bus.mem_req) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [31:0] aq [8];
    int na, treq, tval, ng, gap;

    rst = 1'b1; rdy = 1'b1;
    bus.stall_hold = 1'b0; bus.br_taken = 1'b0; bus.br_addr = '0;
    bus.mem_gnt = 1'b0; bus.mem_din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_inst", bus.if_inst, 32'h0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_stall_req", 32'(bus.stall_req), 32'd1);
    rst = 1'b0;

    // First fetch with continuous grant.
    bus.mem_gnt = 1'b1; bus.stall_hold = 1'b1;
    na = 0; treq = -1; tval = -1;
    for (int i = 0; i < 30; i++) begin
      if (bus.mem_req) begin
        if (treq < 0) treq = i;
        if (na < 8) aq[na] = bus.mem_a;
        na++;
      end
      cyc();
      if (bus.if_valid) begin tval = i + 1; break; end
    end
    chk("t1_nreq", 32'(na), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_addr", aq[i], 32'(i));
    chk("t1_latency", 32'(tval - treq), 32'd5);
    chk("t1_pc", bus.if_pc, 32'h0);
    chk("t1_inst", bus.if_inst, 32'h00500093);

    // Downstream stalled: everything holds.
    repeat (4) begin
      cyc();
      chk("hold_valid", 32'(bus.if_valid), 32'd1);
      chk("hold_req", 32'(bus.mem_req), 32'd0);
      chk("hold_pc", bus.if_pc, 32'h0);
      chk("hold_inst", bus.if_inst, 32'h00500093);
    end
    bus.stall_hold = 1'b0;
    cyc();
    bus.stall_hold = 1'b1;
    chk("consume_clr", 32'(bus.if_valid), 32'd0);

    // Fetch at 0x4 with a 3-cycle grant gap after the second byte.
    ng = 0; gap = 0; treq = -1; tval = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_req && treq < 0) begin
        treq = i;
        chk("t2_first_a", bus.mem_a, 32'h4);
      end
      if (bus.mem_req && ng == 2 && gap < 3) begin
        bus.mem_gnt = 1'b0;
        gap++;
      end else begin
        bus.mem_gnt = 1'b1;
      end
      if (bus.mem_req && bus.mem_gnt && ng == 2) chk("t2_resume_a", bus.mem_a, 32'h6);
      if (bus.mem_req && bus.mem_gnt) ng++;
      cyc();
      if (bus.if_valid) begin tval = i + 1; break; end
    end
    bus.mem_gnt = 1'b1;
    chk("t2_latency", 32'(tval - treq), 32'd8);
    chk("t2_pc", bus.if_pc, 32'h4);
    chk("t2_inst", bus.if_inst, word_at(32'h4));

    // Redirect to 0x103 while byte 2 of the fetch at 0x8 is issued.
    bus.stall_hold = 1'b0; cyc(); bus.stall_hold = 1'b1;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req && ng == 2) begin
        chk("t3_at_byte2", bus.mem_a, 32'hA);
        bus.br_taken = 1'b1;
        bus.br_addr = 32'h103;
      end
      if (bus.mem_req) ng++;
      cyc();
      bus.br_taken = 1'b0;
      if (ng == 3) break;
    end
    chk("t3_br_valid", 32'(bus.if_valid), 32'd0);
    wait_sig(1'b0, "t3_req_seen");
    chk("t3_first_a", bus.mem_a, 32'h100);
    wait_sig(1'b1, "t3_done");
    chk("t3_pc", bus.if_pc, 32'h100);
    chk("t3_inst", bus.if_inst, word_at(32'h100));

    // Redirect in the same cycle the last byte completes.
    bus.stall_hold = 1'b0; cyc(); bus.stall_hold = 1'b1;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      if (ng == 4) begin
        bus.br_taken = 1'b1;
        bus.br_addr = 32'h200;
        cyc();
        bus.br_taken = 1'b0;
        break;
      end
      if (bus.mem_req) ng++;
      cyc();
    end
    chk("t4_valid_low", 32'(bus.if_valid), 32'd0);
    wait_sig(1'b0, "t4_req_seen");
    chk("t4_first_a", bus.mem_a, 32'h200);
    wait_sig(1'b1, "t4_done");
    chk("t4_pc", bus.if_pc, 32'h200);

    // rdy low freezes everything, including consume and redirect.
    rdy = 1'b0; bus.stall_hold = 1'b0; bus.br_taken = 1'b1; bus.br_addr = 32'h300;
    repeat (3) begin
      cyc();
      chk("frz_valid", 32'(bus.if_valid), 32'd1);
      chk("frz_pc", bus.if_pc, 32'h200);
    end
    rdy = 1'b1; bus.br_taken = 1'b0;
    cyc();
    bus.stall_hold = 1'b1;
    wait_sig(1'b0, "frz_req_seen");
    cyc();
    rdy = 1'b0;
    repeat (3) begin
      cyc();
      chk("frz_mem_a", bus.mem_a, 32'h205);
      chk("frz_mem_req", 32'(bus.mem_req), 32'd1);
    end
    rdy = 1'b1;
    wait_sig(1'b1, "frz_done");
    chk("frz_done_pc", bus.if_pc, 32'h204);
    chk("frz_done_inst", bus.if_inst, word_at(32'h204));

`ifdef IFETCH_ICACHE_EN
    bus.br_taken = 1'b1; bus.br_addr = 32'h0; cyc(); bus.br_taken = 1'b0;
    wait_sig(1'b1, "c_fill0");
    bus.mem_gnt = 1'b0;
    bus.br_taken = 1'b1; cyc(); bus.br_taken = 1'b0;
    chk("c_br_clr", 32'(bus.if_valid), 32'd0);
    cyc();
    chk("c_hit_valid", 32'(bus.if_valid), 32'd1);
    chk("c_hit_req", 32'(bus.mem_req), 32'd0);
    chk("c_hit_pc", bus.if_pc, 32'h0);
    chk("c_hit_inst", bus.if_inst, 32'h00500093);
    bus.mem_gnt = 1'b1;
    bus.br_taken = 1'b1; bus.br_addr = 32'h100; cyc(); bus.br_taken = 1'b0;
    wait_sig(1'b1, "c_fill100");
    bus.br_taken = 1'b1; bus.br_addr = 32'h0; cyc(); bus.br_taken = 1'b0;
    cyc();
    chk("c_evict_req", 32'(bus.mem_req), 32'd1);
    chk("c_evict_valid", 32'(bus.if_valid), 32'd0);
    wait_sig(1'b1, "c_refill");
`endif

    // Random traffic against the model.
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      rdy            = ($urandom_range(15) != 0);
      bus.mem_gnt    = ($urandom_range(3) != 0);
      bus.stall_hold = ($urandom_range(2) == 0);
      bus.br_taken   = ($urandom_range(39) == 0);
      bus.br_addr    = ($urandom_range(1) != 0) ? 32'($urandom_range(1023)) : $urandom;
      cyc();
    end
    rdy = 1'b1; bus.br_taken = 1'b0;
    chk("rand_progress", 32'(consumed >= 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
